// File: rtl/weight_sink_pkg.sv
// Shared types and constants for the weight stream sink.
//   sink_state_e   : load FSM states (LOAD accepting beats, FULL all beats stored)
//   CHECKSUM_WIDTH : width of the optional running element checksum
package weight_sink_pkg;

  localparam int unsigned CHECKSUM_WIDTH = 32;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } sink_state_e;

endpackage

// File: rtl/weight_stream_sink_if.sv
// Valid/ready beat stream carrying P elements of PREC bits each.
//   data_in       : unpacked element array, element j lands in word bits [PREC*j +: PREC]
//   data_in_valid : producer has a beat
//   data_in_ready : sink accepts the beat this cycle
// master = producer side, slave = sink side.
interface weight_stream_sink_if #(
  parameter int unsigned PREC = 16,
  parameter int unsigned P    = 4
);

  logic [PREC-1:0] data_in [P];
  logic            data_in_valid;
  logic            data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );

endinterface

// File: rtl/weight_sink_ram.sv
// Simple dual-port RAM: one write port, one read port with a two-stage
// pipeline where both stages advance only on ce. The array is not reset;
// the read pipeline registers are.
//   clk, rst     : clock, asynchronous active-low reset (pipeline only)
//   we/waddr/wdata : write port
//   ce/raddr/q   : read port, q = mem[raddr] two ce cycles later
module weight_sink_ram #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      q
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q1;
  logic             in_range_c;

  // Addresses past DEPTH read as zero rather than indexing off the array.
  assign in_range_c = (raddr < ADDR_WIDTH'(DEPTH));

  // Write port; no reset so the array maps onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read pipeline; a same-edge write is not visible, so the old word is returned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q1 <= '0;
      q     <= '0;
    end else if (ce) begin
      rd_q1 <= in_range_c ? mem[raddr[IDX_W-1:0]] : '0;
      q     <= rd_q1;
    end
  end

endmodule

// File: rtl/weight_stream_sink.sv
// Weight stream sink: collects DEPTH beats of P packed elements into a RAM,
// then stops accepting until cleared. RAM is readable at any time.
// Optional feature macro: WEIGHT_SINK_CHECKSUM_EN adds a 32-bit wrapping
// checksum output of all accepted elements.
//   clk, rst           : clock, asynchronous active-low reset
//   s_in               : beat stream (data_in, data_in_valid, data_in_ready)
//   clear              : synchronous restart of a load (RAM retained)
//   load_done          : all DEPTH beats stored
//   beat_count         : beats accepted in the current load
//   address0, ce0, q0  : read port, two ce0-cycle latency
//   checksum           : (macro only) sum of accepted elements
module weight_stream_sink
  import weight_sink_pkg::*;
#(
  parameter int unsigned DATA_IN_PRECISION_0       = 16,
  parameter int unsigned DATA_IN_PARALLELISM_DIM_0 = 4,
  parameter int unsigned DATA_IN_PARALLELISM_DIM_1 = 1,
  parameter int unsigned DEPTH                     = 8,
  parameter int unsigned ADDR_WIDTH                = $clog2(DEPTH) + 1,
  localparam int unsigned P      = DATA_IN_PARALLELISM_DIM_0 * DATA_IN_PARALLELISM_DIM_1,
  localparam int unsigned WORD_W = P * DATA_IN_PRECISION_0
) (
  input  logic                      clk,
  input  logic                      rst,
  weight_stream_sink_if.slave       s_in,
  input  logic                      clear,
  output logic                      load_done,
  output logic [ADDR_WIDTH-1:0]     beat_count,
  input  logic [ADDR_WIDTH-1:0]     address0,
  input  logic                      ce0,
  output logic [WORD_W-1:0]         q0
`ifdef WEIGHT_SINK_CHECKSUM_EN
  ,
  output logic [CHECKSUM_WIDTH-1:0] checksum
`endif
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sink_state_e       state;
  logic              accept_c;
  logic [WORD_W-1:0] word_c;

  // Ready drops combinationally under clear so a same-cycle beat is dropped.
  assign s_in.data_in_ready = (state == LOAD) && !clear;
  assign accept_c           = s_in.data_in_valid && s_in.data_in_ready;

  // Pack elements into a RAM word.
  for (genvar g = 0; g < P; g++) begin : g_pack
    assign word_c[DATA_IN_PRECISION_0*g +: DATA_IN_PRECISION_0] = s_in.data_in[g];
  end

  // Load FSM: count beats, go FULL on the edge accepting the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      beat_count <= '0;
      load_done  <= 1'b0;
    end else if (clear) begin
      state      <= LOAD;
      beat_count <= '0;
      load_done  <= 1'b0;
    end else if (accept_c) begin
      beat_count <= beat_count + ADDR_WIDTH'(1);
      if (beat_count == ADDR_WIDTH'(DEPTH - 1)) begin
        state     <= FULL;
        load_done <= 1'b1;
      end
    end
  end

  weight_sink_ram #(
    .WIDTH      (WORD_W),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (accept_c),
    .waddr (beat_count[IDX_W-1:0]),
    .wdata (word_c),
    .ce    (ce0),
    .raddr (address0),
    .q     (q0)
  );

`ifdef WEIGHT_SINK_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] psum_c [P+1];

  // Ripple sum of the zero-extended elements of the current beat.
  assign psum_c[0] = '0;
  for (genvar g = 0; g < P; g++) begin : g_sum
    assign psum_c[g+1] = psum_c[g] + CHECKSUM_WIDTH'(s_in.data_in[g]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (clear) begin
      checksum <= '0;
    end else if (accept_c) begin
      checksum <= checksum + psum_c[P];
    end
  end
`endif

endmodule

// File: tb/tb_weight_stream_sink.sv
// Self-checking bench for weight_stream_sink (default parameters).
// A behavioural model (array of words, beat counter, full flag, running sum)
// predicts every output; stimulus is directed steps plus random data/valid.
module tb_weight_stream_sink;

  localparam int unsigned PREC  = 16;
  localparam int unsigned P     = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned W     = P * PREC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          load_done;
  logic [AW-1:0] beat_count;
  logic [AW-1:0] address0 = '0;
  logic          ce0 = 1'b0;
  logic [W-1:0]  q0;
`ifdef WEIGHT_SINK_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  weight_stream_sink_if #(.PREC(PREC), .P(P)) bus ();

  weight_stream_sink dut (
    .clk        (clk),
    .rst        (rst),
    .s_in       (bus),
    .clear      (clear),
    .load_done  (load_done),
    .beat_count (beat_count),
    .address0   (address0),
    .ce0        (ce0),
    .q0         (q0)
`ifdef WEIGHT_SINK_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] ref_mem [DEPTH];
  int           ref_count = 0;
  bit           ref_full  = 1'b0;
  logic [31:0]  ref_sum   = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    check("beat_count", 64'(beat_count), 64'(ref_count));
    check("load_done", 64'(load_done), 64'(ref_full));
`ifdef WEIGHT_SINK_CHECKSUM_EN
    check("checksum", 64'(checksum), 64'(ref_sum));
`endif
  endtask

  // One clock of stream stimulus. mode 0: random, 1: beat*4+j, 2: all ones.
  task automatic cycle(input bit v, input bit clr, input int mode);
    logic [PREC-1:0] e;
    logic [W-1:0]    w;
    logic [31:0]     s;
    bit              exp_ready;
    bit              acc;
    w = '0;
    s = '0;
    for (int j = 0; j < P; j++) begin
      case (mode)
        0:       e = PREC'($urandom);
        1:       e = PREC'(ref_count * 4 + j);
        default: e = '1;
      endcase
      bus.data_in[j] = e;
      w = w + (W'(e) << (PREC * j));
      s = s + 32'(e);
    end
    bus.data_in_valid = v;
    clear = clr;
    #1;
    exp_ready = !ref_full && !clr;
    check("data_in_ready", 64'(bus.data_in_ready), 64'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (clr) begin
      ref_count = 0;
      ref_full  = 1'b0;
      ref_sum   = '0;
    end else if (acc) begin
      ref_mem[ref_count] = w;
      ref_count++;
      ref_sum = ref_sum + s;
      if (ref_count == DEPTH) ref_full = 1'b1;
    end
    check_status();
    bus.data_in_valid = 1'b0;
    clear = 1'b0;
  endtask

  // Pipelined read of every address, then a ce0-low hold check.
  task automatic read_all();
    logic [W-1:0] expq [$];
    int           a;
    for (int i = 0; i < DEPTH + 2; i++) begin
      a = (i < DEPTH) ? i : ((i == DEPTH) ? 3 : 5);
      address0 = AW'(a);
      ce0 = 1'b1;
      expq.push_back(ref_mem[a]);
      @(posedge clk);
      #1;
      if (i >= 1) check("q0_read", q0, expq.pop_front());
    end
    ce0 = 1'b0;
    address0 = AW'(1);
    repeat (2) @(posedge clk);
    #1;
    check("q0_hold", q0, ref_mem[3]);
    ce0 = 1'b1;
    @(posedge clk);
    #1;
    check("q0_stage1_hold", q0, ref_mem[5]);
    ce0 = 1'b0;
  endtask

  initial begin
    logic [W-1:0] old_word;
    bus.data_in_valid = 1'b0;
    for (int j = 0; j < P; j++) bus.data_in[j] = '0;

    // Reset values
    #3;
    check("rst_beat_count", 64'(beat_count), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_q0", q0, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst_ready", 64'(bus.data_in_ready), 64'd1);

    // Full load with pattern beat*4+j, valid always high
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1);
    check("pattern_word0", ref_mem[0], 64'h0003_0002_0001_0000);
    read_all();

    // FULL: valid held high, nothing written
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
    read_all();

    // Clear, then valid toggling 1010...
    cycle(1'b0, 1'b1, 0);
    for (int i = 0; i < 2 * DEPTH; i++) cycle((i % 2) == 0, 1'b0, 0);
    read_all();

    // Clear with a valid beat at beat 3, then reload from address 0
    cycle(1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 0);
    old_word = ref_mem[0];
    address0 = '0;
    ce0 = 1'b1;
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    ce0 = 1'b0;
    check("read_during_write_old", q0, old_word);
    for (int i = 2; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    read_all();

    // Asynchronous reset after 5 beats
    cycle(1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 0);
    #2;
    rst = 1'b0;
    #1;
    ref_count = 0;
    ref_full  = 1'b0;
    ref_sum   = '0;
    check_status();
    check("async_rst_q0", q0, 64'd0);
    check("async_rst_ready", 64'(bus.data_in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 0);
    read_all();

`ifdef WEIGHT_SINK_CHECKSUM_EN
    // All-ones elements: checksum = 32 * 0xFFFF
    cycle(1'b0, 1'b1, 0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 2);
    check("checksum_ffff", 64'(checksum), 64'h001F_FFE0);
    cycle(1'b0, 1'b1, 0);
    check("checksum_clear", 64'(checksum), 64'd0);
`endif

    // Random valid/clear mix
    for (int i = 0; i < 80; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, 0);
    end
    read_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/weight_stream_sink.md
WEIGHT_STREAM_SINK -- requirements
Module: weight_stream_sink

Interface
REQ-001 Parameter DATA_IN_PRECISION_0, default 16, element width in bits.
REQ-002 Parameter DATA_IN_PARALLELISM_DIM_0, default 4, elements per beat in dim 0.
REQ-003 Parameter DATA_IN_PARALLELISM_DIM_1, default 1, elements per beat in dim 1; P = DIM_0*DIM_1.
REQ-004 Parameter DEPTH, default 8, number of beats (RAM words) per load.
REQ-005 Parameter ADDR_WIDTH, default $clog2(DEPTH)+1, read-address width.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 data_in  input  P x DATA_IN_PRECISION_0  unpacked element array; element j maps to word bits [PREC*j +: PREC].
REQ-009 data_in_valid  input  1  producer beat valid.
REQ-010 data_in_ready  output  1  sink accepts beat.
REQ-011 clear  input  1  synchronous restart of a load.
REQ-012 load_done  output  1  all DEPTH beats stored.
REQ-013 beat_count  output  ADDR_WIDTH  beats accepted in current load.
REQ-014 address0  input  ADDR_WIDTH  read address.
REQ-015 ce0  input  1  read clock-enable.
REQ-016 q0  output  P*DATA_IN_PRECISION_0  read data.

Function
REQ-017 FSM states LOAD and FULL; reset state LOAD.
REQ-018 LOAD: data_in_ready=1; beat accepted when data_in_valid && data_in_ready; packed word written to RAM[beat_count]; beat_count increments.
REQ-019 Acceptance of beat DEPTH-1 moves LOAD->FULL on same edge; beat_count=DEPTH, load_done=1 from next cycle.
REQ-020 FULL: data_in_ready=0, no writes, beat_count holds, load_done=1.
REQ-021 clear=1 in any state: next cycle state LOAD, beat_count=0, load_done=0; RAM contents retained; clear has priority over a same-cycle beat (beat dropped, data_in_ready forced 0 while clear=1).
REQ-022 data_in_valid low: no state change; valid may toggle arbitrarily between beats.
REQ-023 Read port: 2-cycle latency, both pipeline stages advance only when ce0=1 (q0 = RAM[address0] after two ce0 cycles); q0 holds when ce0=0.
REQ-024 Same-cycle read and write to same address returns the old word.
REQ-025 address0 >= DEPTH returns undefined data; no other effect.
REQ-026 Reads permitted in any state, including during LOAD.

Reset
REQ-027 rst low: state LOAD, beat_count 0, load_done 0, data_in_ready 1 after release, q0 pipeline registers 0, checksum 0; RAM not reset.
REQ-028 Reset mid-load discards progress; the next load restarts at address 0.

Configuration
REQ-029 Macro WEIGHT_SINK_CHECKSUM_EN defined: extra output checksum, 32 bits, wrapping sum of all accepted elements zero-extended, cleared by reset and clear, updated on the accepting edge.
REQ-030 Macro undefined: no checksum port or logic; all other behaviour identical.

Structure
REQ-031 Package weight_sink_pkg holds state enum (LOAD, FULL) and CHECKSUM_WIDTH=32.
REQ-032 Sub-module weight_sink_ram: simple dual-port RAM, one write port, two-stage ce-gated read port, no reset on array.

Verification
REQ-033 Defaults, 8 beats with element values beat*4+j, valid always high -> load_done after 8th beat, data_in_ready low after it, reads of addr 0..7 return the same packed words 2 cycles after ce0.
REQ-034 Valid toggling 1010... for 8 beats -> exactly 8 writes, beat_count steps 0..8, no skipped or duplicated addresses.
REQ-035 FULL with valid held high for 5 cycles -> no writes, RAM unchanged, beat_count=8.
REQ-036 clear asserted with valid on beat 3 -> beat dropped, beat_count=0 next cycle, a new 8-beat load overwrites from address 0.
REQ-037 rst low after 5 beats -> outputs at reset values immediately (asynchronous), reload from address 0 succeeds.
REQ-038 With WEIGHT_SINK_CHECKSUM_EN, 8 beats of all elements 0xFFFF -> checksum 32*0xFFFF = 0x001FFFE0; clear -> 0.
